// File: rtl/bit_serializer.sv
// bit_serializer: one-word buffered parallel-to-serial front end with valid/ready input
module bit_serializer #(
  parameter int DATA_W = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic [15:0]       words_sent
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] hold_data, sh, sh_nx;
  logic [CW-1:0] cnt;
  logic hold_full, active, last, load, accept;
  assign active = state == SHIFT;
  assign last = active && cnt == CNT_LAST;
  assign load = hold_full && (!active || last);
  assign s_ready = rstn && (!hold_full || load);
  assign accept = s_valid && s_ready;
  assign sh_nx = MSB_FIRST ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
  assign ser_valid = active;
  assign ser_out = active ? (MSB_FIRST ? sh[DATA_W-1] : sh[0]) : IDLE_BIT;
  assign busy = active | hold_full;
  // shifter state register
  always_ff @(posedge clk)
    state <= !rstn ? IDLE : state_nx;
  // a pending word keeps the shifter running; otherwise it stops after the last bit
  always_comb
    state_nx = load ? SHIFT : last ? IDLE : state;
  // shift register, bit counter, buffer flag and completed-word counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh <= '0;
      cnt <= '0;
      hold_full <= 1'b0;
      words_sent <= '0;
    end else begin
      if (load) begin
        sh <= hold_data;
        cnt <= '0;
      end else if (active) begin
        sh <= sh_nx;
        cnt <= cnt + CW'(1);
      end
      if (accept) hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
      if (last) words_sent <= words_sent + 16'd1;
    end
  end
  // holding buffer captures each handshake; its contents are only used while hold_full
  always_ff @(posedge clk)
    if (accept) hold_data <= s_data;
endmodule
